// File: rtl/encoder_round_scheduler_if.sv
// Handshake and status bundle between the round scheduler
// and the stage controllers / memory mux.
interface encoder_round_scheduler_if #(
    parameter int NUM_STAGES = 5,
    parameter int RW         = 5
);
    logic                  i_start;
    logic [NUM_STAGES-1:0] i_stage_ready;
    logic [NUM_STAGES-1:0] o_stage_start;
    logic [2:0]            o_mem_sel;
    logic [RW-1:0]         o_round_idx;
    logic                  o_swap_bufs;
    logic                  o_busy;
    logic                  o_ready;
    logic                  o_err;

    modport slave (
        input  i_start,
        input  i_stage_ready,
        output o_stage_start,
        output o_mem_sel,
        output o_round_idx,
        output o_swap_bufs,
        output o_busy,
        output o_ready,
        output o_err
    );

    modport master (
        output i_start,
        output i_stage_ready,
        input  o_stage_start,
        input  o_mem_sel,
        input  o_round_idx,
        input  o_swap_bufs,
        input  o_busy,
        input  o_ready,
        input  o_err
    );
endinterface

// File: rtl/encoder_round_scheduler.sv
// Round sequencer: launches each stage controller in order,
// swaps ping-pong buffers per stage, watchdogs hung stages.
module encoder_round_scheduler #(
    parameter int NUM_STAGES = 5,
    parameter int ROUNDS     = 24,
    parameter int RW         = 5,
    parameter int TIMEOUT    = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    encoder_round_scheduler_if.slave   if_sched
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_STAGES-1:0] ONE_HOT0 = 1;
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_WAIT,
        S_SWAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_stage;
    logic [2:0]            w_stage_nxt;
    logic [RW-1:0]         r_round;
    logic [RW-1:0]         w_round_nxt;
    logic [WDW-1:0]        r_wd;
    logic [WDW-1:0]        w_wd_nxt;
    logic                  r_err;
    logic                  w_err_nxt;

    logic [NUM_STAGES-1:0] w_stage_onehot;
    logic                  w_sel_ready;
    logic [NUM_STAGES-1:0] w_stage_start;
    logic [2:0]            w_mem_sel;
    logic                  w_swap_bufs;
    logic                  w_busy;
    logic                  w_ready;

    // Only the ready bit of the stage being waited on counts.
    assign w_stage_onehot = ONE_HOT0 << r_stage;
    assign w_sel_ready =
        |(if_sched.i_stage_ready & w_stage_onehot);

    // State, counters and sticky error register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_round <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_round <= w_round_nxt;
            r_wd    <= w_wd_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter updates and Moore outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_stage_nxt   = r_stage;
        w_round_nxt   = r_round;
        w_wd_nxt      = r_wd;
        w_err_nxt     = r_err;
        w_stage_start = '0;
        w_mem_sel     = '0;
        w_swap_bufs   = 1'b0;
        w_busy        = 1'b0;
        w_ready       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (if_sched.i_start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_busy      = 1'b1;
                w_stage_nxt = '0;
                w_round_nxt = '0;
                w_err_nxt   = 1'b0;
                if (!if_sched.i_start) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_busy        = 1'b1;
                w_mem_sel     = r_stage;
                w_stage_start = w_stage_onehot;
                w_wd_nxt      = '0;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                w_busy    = 1'b1;
                w_mem_sel = r_stage;
                if (w_sel_ready) begin
                    w_state_nxt = S_SWAP;
                end else if (r_wd == WD_LAST) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WDW'(1);
                end
            end
            S_SWAP: begin
                w_busy      = 1'b1;
                w_mem_sel   = r_stage;
                w_swap_bufs = 1'b1;
                if (r_stage != LAST_STAGE) begin
                    w_stage_nxt = r_stage + 3'd1;
                    w_state_nxt = S_LAUNCH;
                end else if (r_round != LAST_ROUND) begin
                    w_stage_nxt = '0;
                    w_round_nxt = r_round + RW'(1);
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (if_sched.i_start) begin
                    w_state_nxt = S_ARM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign if_sched.o_stage_start = w_stage_start;
    assign if_sched.o_mem_sel     = w_mem_sel;
    assign if_sched.o_round_idx   = r_round;
    assign if_sched.o_swap_bufs   = w_swap_bufs;
    assign if_sched.o_busy        = w_busy;
    assign if_sched.o_ready       = w_ready;
    assign if_sched.o_err         = r_err;
endmodule
